cic_dec_ctrl: RTL and testbench
===============================

CIC_DEC_CTRL -- requirements
Module: cic_dec_ctrl

Interface
REQ-001 Parameter SEL_MAX, default 6, largest legal oversampling select (ratio 2^SEL_MAX = 64).
REQ-002 Parameter SETTLE, default 2, decimated strobes suppressed after any restart or ratio change.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  run request; low holds the decimator in IDLE.
REQ-006 cfg_valid  in  1  new ratio request.
REQ-007 cfg_os_sel  in  3  requested select; ratio R = 2^sel.
REQ-008 cfg_ready  out  1  controller can accept a request this cycle.
REQ-009 os_sel  out  3  active select driven to integrator/comb.
REQ-010 dec_stb  out  1  one-cycle decimation strobe (comb-side enable).
REQ-011 phase  out  6  position within current decimation period.
REQ-012 flush  out  1  one-cycle clear pulse for integrator and comb state.
REQ-013 out_valid  out  1  filter output sample is valid this cycle.
REQ-014 busy  out  1  high in DRAIN or FLUSH.

Function
REQ-015 States: IDLE, RUN, DRAIN, FLUSH; encoding free.
REQ-016 cfg_os_sel > SEL_MAX is clamped to SEL_MAX on acceptance.
REQ-017 Acceptance = cfg_valid && cfg_ready; cfg_ready = 1 in IDLE and RUN, 0 in DRAIN and FLUSH.
REQ-018 IDLE: phase held 0, dec_stb 0, out_valid 0; accepted request loads os_sel on the next edge, no flush.
REQ-019 IDLE -> FLUSH when enable = 1.
REQ-020 FLUSH: lasts exactly one cycle; flush = 1; phase forced 0; settle counter loaded with SETTLE; next state RUN (IDLE if enable = 0).
REQ-021 RUN: phase increments by 1 each cycle, wraps R-1 -> 0; dec_stb = 1 exactly when phase == R-1.
REQ-022 R = 1 (os_sel 0): phase stays 0, dec_stb = 1 every RUN cycle.
REQ-023 out_valid = dec_stb && settle counter == 0; each dec_stb with counter > 0 decrements it and is suppressed.
REQ-024 RUN with accepted request: pending select captured; next state DRAIN; current ratio continues.
REQ-025 DRAIN: phase keeps counting at the old ratio; in the cycle phase == R-1 (dec_stb still asserted, old-ratio sample completes), on that edge os_sel <= pending select and state -> FLUSH.
REQ-026 Request accepted in the same cycle phase == R-1 in RUN: that strobe completes in RUN; DRAIN then waits a full old period.
REQ-027 enable = 0 in RUN: next state IDLE immediately; partial period discarded, phase -> 0.
REQ-028 enable = 0 in DRAIN: pending select applied to os_sel on that edge; next state IDLE.
REQ-029 os_sel changes only on edges entering FLUSH or while in IDLE; never mid-period in RUN.
REQ-030 All outputs registered except cfg_ready, dec_stb, out_valid, busy (decoded from state/phase/counter).

Reset
REQ-031 reset_n low asynchronously forces: state IDLE, os_sel 0, phase 0, flush 0, settle counter 0, pending select 0; hence dec_stb 0, out_valid 0, busy 0, cfg_ready 1.
REQ-032 Reset asserted mid-DRAIN discards the pending select; os_sel returns to 0.
REQ-033 After reset release, no activity until enable = 1.

Verification
REQ-034 Reset, write sel 3 in IDLE, enable = 1 -> one flush pulse, dec_stb every 8 cycles, first 2 strobes with out_valid 0, third with out_valid 1.
REQ-035 RUN sel 3 at phase 2, request sel 1 -> busy high, strobe at phase 7 at old ratio, os_sel = 1 next edge, flush pulse, then strobes every 2 cycles with 2 suppressed.
REQ-036 Request sel 7 -> os_sel = 6, period 64 cycles, phase wraps 63 -> 0.
REQ-037 Sel 0 running -> dec_stb every cycle, phase constant 0; cfg_valid held during DRAIN/FLUSH sees cfg_ready 0, not accepted twice.
REQ-038 enable dropped in DRAIN with pending sel 5 -> IDLE next cycle, os_sel = 5, no flush; re-enable -> flush then 32-cycle period.
REQ-039 reset_n pulsed low mid-DRAIN (asynchronous, between edges) -> all outputs at reset values immediately, os_sel 0, pending discarded.

Source files
------------

// File: rtl/cic_dec_ctrl.sv
// Rate controller for a CIC decimator: sequences ratio changes so the select only
// moves on period boundaries, with a flush pulse and settling strobes after each restart.
module cic_dec_ctrl #(
  parameter int SEL_MAX = 6,
  parameter int SETTLE  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       cfg_valid,
  input  logic [2:0] cfg_os_sel,
  output logic       cfg_ready,
  output logic [2:0] os_sel,
  output logic       dec_stb,
  output logic [5:0] phase,
  output logic       flush,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

  state_t     state, next_state;
  logic [2:0] pending_sel;
  logic [2:0] sel_clamped;
  logic [7:0] settle_cnt;
  logic [6:0] ratio;
  logic [5:0] last_phase;
  logic       at_last;
  logic       accept;
  logic       counting;

  assign sel_clamped = (cfg_os_sel > 3'(SEL_MAX)) ? 3'(SEL_MAX) : cfg_os_sel;
  assign ratio       = 7'd1 << os_sel;
  assign last_phase  = 6'(ratio - 7'd1);
  assign at_last     = (phase == last_phase);
  assign counting    = (state == RUN) || (state == DRAIN);
  assign accept      = cfg_valid && cfg_ready;

  always_comb begin
    next_state = state;
    cfg_ready  = 1'b0;
    dec_stb    = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (enable) next_state = FLUSH;
      end
      FLUSH: begin
        busy       = 1'b1;
        next_state = enable ? RUN : IDLE;
      end
      RUN: begin
        cfg_ready = 1'b1;
        dec_stb   = at_last;
        if (!enable)     next_state = IDLE;
        else if (accept) next_state = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        dec_stb = at_last;
        if (!enable)      next_state = IDLE;
        else if (at_last) next_state = FLUSH;
      end
      default: next_state = IDLE;
    endcase
    out_valid = dec_stb && (settle_cnt == 8'd0);
  end

  // The old ratio keeps running through DRAIN; the select only switches on the
  // edge that closes the final old-ratio period (or when the run is abandoned).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      os_sel      <= 3'd0;
      phase       <= 6'd0;
      flush       <= 1'b0;
      settle_cnt  <= 8'd0;
      pending_sel <= 3'd0;
    end else begin
      state <= next_state;
      flush <= (next_state == FLUSH);

      if (counting && (next_state == RUN || next_state == DRAIN))
        phase <= at_last ? 6'd0 : phase + 6'd1;
      else
        phase <= 6'd0;

      if (state == FLUSH)
        settle_cnt <= 8'(SETTLE);
      else if (dec_stb && settle_cnt != 8'd0)
        settle_cnt <= settle_cnt - 8'd1;

      if (state == RUN && accept)
        pending_sel <= sel_clamped;

      if (state == IDLE && accept)
        os_sel <= sel_clamped;
      else if (state == DRAIN && (!enable || at_last))
        os_sel <= pending_sel;
    end
  end

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed bench for cic_dec_ctrl: strobes are checked against a queue of expected
// strobe records (select, phase, out_valid, spacing) filled as each step is driven.
module tb_cic_dec_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       cfg_valid;
  logic [2:0] cfg_os_sel;
  logic       cfg_ready;
  logic [2:0] os_sel;
  logic       dec_stb;
  logic [5:0] phase;
  logic       flush;
  logic       out_valid;
  logic       busy;

  typedef struct {
    logic [2:0] sel;
    logic [5:0] ph;
    logic       ov;
    int         gap;
  } stb_rec_t;

  stb_rec_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_stb_cyc = 0;
  int flush_cnt = 0;
  int flush_mark;

  cic_dec_ctrl #(.SEL_MAX(6), .SETTLE(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_os_sel(cfg_os_sel), .cfg_ready(cfg_ready), .os_sel(os_sel),
    .dec_stb(dec_stb), .phase(phase), .flush(flush), .out_valid(out_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] s, input logic [5:0] p, input logic v, input int g);
    stb_rec_t r;
    r.sel = s; r.ph = p; r.ov = v; r.gap = g;
    sb.push_back(r);
  endtask

  task automatic wait_sb(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check("strobe_queue_drained", sb.size(), 0);
  endtask

  task automatic wait_phase(input logic [5:0] p, input int limit);
    int n = 0;
    while (phase !== p && n < limit) begin
      tick();
      n++;
    end
    check("reach_phase", phase, p);
  endtask

  task automatic wait_flush(input int limit);
    int n = 0;
    while (flush !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check("reach_flush", flush, 1);
  endtask

  // Strobe monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (flush === 1'b1) flush_cnt++;
    if (dec_stb === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL unexpected_strobe observed=1 expected=0 at cycle %0d", cyc);
      end else begin
        stb_rec_t r;
        r = sb.pop_front();
        check("stb_os_sel", os_sel, r.sel);
        check("stb_phase", phase, r.ph);
        check("stb_out_valid", out_valid, r.ov);
        if (r.gap != 0) check("stb_spacing", cyc - last_stb_cyc, r.gap);
      end
      last_stb_cyc = cyc;
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_os_sel = 3'd0;
    tick(); tick();
    check("rst_os_sel", os_sel, 0);
    check("rst_phase", phase, 0);
    check("rst_flush", flush, 0);
    check("rst_dec_stb", dec_stb, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    #2 reset_n = 1'b1;
    tick(); tick();
    check("idle_phase", phase, 0);
    check("idle_flush", flush, 0);

    // Ratio 8 from IDLE, then enable: one flush, two suppressed strobes.
    cfg_valid = 1'b1; cfg_os_sel = 3'd3;
    tick();
    cfg_valid = 1'b0;
    check("idle_load_sel", os_sel, 3);
    check("idle_load_noflush", flush, 0);
    push(3, 7, 0, 0); push(3, 7, 0, 8); push(3, 7, 1, 8);
    enable = 1'b1;
    tick();
    check("s1_flush", flush, 1);
    check("s1_flush_busy", busy, 1);
    check("s1_flush_ready", cfg_ready, 0);
    check("s1_flush_phase", phase, 0);
    tick();
    check("s1_run_flush_low", flush, 0);
    check("s1_run_busy_low", busy, 0);
    wait_sb(40);
    check("s1_flush_count", flush_cnt, 1);

    // Change 8 -> 2 mid-period: old period completes before the switch.
    wait_phase(6'd2, 20);
    cfg_valid = 1'b1; cfg_os_sel = 3'd1;
    push(3, 7, 1, 8); push(1, 1, 0, 3); push(1, 1, 0, 2); push(1, 1, 1, 2);
    tick();
    cfg_valid = 1'b0;
    check("s2_busy", busy, 1);
    check("s2_ready_low", cfg_ready, 0);
    check("s2_old_sel_held", os_sel, 3);
    check("s2_phase_counts", phase, 3);
    wait_flush(20);
    check("s2_new_sel", os_sel, 1);
    check("s2_flush_phase", phase, 0);
    wait_sb(20);
    check("s2_flush_count", flush_cnt, 2);

    // Out-of-range select clamps to 6: 64-cycle period with 63 -> 0 wrap.
    wait_phase(6'd0, 10);
    cfg_valid = 1'b1; cfg_os_sel = 3'd7;
    push(1, 1, 1, 2); push(6, 63, 0, 65); push(6, 63, 0, 64); push(6, 63, 1, 64);
    tick();
    cfg_valid = 1'b0;
    wait_flush(20);
    check("s3_clamped_sel", os_sel, 6);
    wait_phase(6'd63, 80);
    tick();
    check("s3_phase_wrap", phase, 0);
    wait_sb(200);

    // Ratio 1 with cfg_valid held through DRAIN/FLUSH: accepted only once.
    wait_phase(6'd10, 80);
    cfg_valid = 1'b1; cfg_os_sel = 3'd0;
    push(6, 63, 1, 64);
    begin
      int n = 0;
      tick();
      while (n < 100) begin
        check("s4_ready_low", cfg_ready, 0);
        if (flush === 1'b1) break;
        check("s4_sel_held", os_sel, 6);
        tick();
        n++;
      end
    end
    check("s4_flush", flush, 1);
    check("s4_new_sel", os_sel, 0);
    cfg_valid = 1'b0;
    push(0, 0, 0, 2); push(0, 0, 0, 1); push(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 3) push(0, 0, 1, 1);
      check("s4_phase_zero", phase, 0);
      check("s4_stb_every_cycle", dec_stb, 1);
      check("s4_not_reaccepted", busy, 0);
    end
    enable = 1'b0;
    tick();
    check("s4_idle_stb", dec_stb, 0);
    check("s4_idle_phase", phase, 0);
    check("s4_idle_ready", cfg_ready, 1);

    // Enable dropped in DRAIN: pending select applied without a flush.
    cfg_valid = 1'b1; cfg_os_sel = 3'd4;
    tick();
    cfg_valid = 1'b0;
    check("s5_idle_sel", os_sel, 4);
    enable = 1'b1;
    tick();
    check("s5_flush", flush, 1);
    tick();
    wait_phase(6'd3, 20);
    cfg_valid = 1'b1; cfg_os_sel = 3'd5;
    tick();
    check("s5_drain_busy", busy, 1);
    cfg_valid = 1'b0; enable = 1'b0;
    flush_mark = flush_cnt;
    tick();
    check("s5_idle_sel_applied", os_sel, 5);
    check("s5_no_flush", flush, 0);
    check("s5_idle_busy", busy, 0);
    check("s5_idle_phase", phase, 0);
    tick(); tick();
    check("s5_flush_count_held", flush_cnt, flush_mark);
    enable = 1'b1;
    push(5, 31, 0, 0); push(5, 31, 0, 32); push(5, 31, 1, 32);
    tick();
    check("s5_reenable_flush", flush, 1);
    check("s5_reenable_sel", os_sel, 5);
    wait_sb(150);

    // Asynchronous reset between edges while DRAIN holds a pending select.
    wait_phase(6'd4, 40);
    cfg_valid = 1'b1; cfg_os_sel = 3'd2;
    tick();
    cfg_valid = 1'b0;
    check("s6_drain_busy", busy, 1);
    #3 reset_n = 1'b0;
    #1;
    check("s6_rst_os_sel", os_sel, 0);
    check("s6_rst_phase", phase, 0);
    check("s6_rst_flush", flush, 0);
    check("s6_rst_dec_stb", dec_stb, 0);
    check("s6_rst_out_valid", out_valid, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_ready", cfg_ready, 1);
    enable = 1'b0;
    #2 reset_n = 1'b1;
    tick(); tick();
    check("s6_quiet_phase", phase, 0);
    check("s6_quiet_flush", flush, 0);
    check("s6_quiet_sel", os_sel, 0);
    enable = 1'b1;
    push(0, 0, 0, 0); push(0, 0, 0, 1); push(0, 0, 1, 1);
    tick();
    check("s6_flush", flush, 1);
    check("s6_sel_discarded", os_sel, 0);
    tick(); tick(); tick();
    enable = 1'b0;
    tick();
    check("s6_idle_stb", dec_stb, 0);
    check("s6_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
